toggle_decoder: RTL

TOGGLE_DECODER -- requirements
Module: toggle_decoder

---
 rtl/toggle_pkg.sv | 6 +
 rtl/toggle_decoder_sync2.sv | 21 ++
 rtl/toggle_decoder.sv | 81 ++++++++
 3 files changed

// File: rtl/toggle_pkg.sv
// toggle_pkg: shared state encoding and default sizing for the toggle decoder
package toggle_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, STALLED} state_t;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/toggle_decoder_sync2.sv
// sync2: two-flop synchronizer whose stages preload a given value during reset
// Ports: Clk clock, Reset sync active-high, load value loaded into both stages
// while Reset is high, d asynchronous input, q synchronized output.
module sync2 (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1 <= load;
            q  <= load;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers T pulses from a T flip-flop's output line and tracks activity
// Ports: Clk clock, Reset sync active-high, Qin toggle line; outputs T recovered
// pulse, Q/Qbar recovered level, toggle_cnt pulse count (wraps), ovf sticky wrap
// flag, active/stalled activity state.
// Build option: define TOGGLE_DECODER_SYNC_EN to put a two-flop synchronizer
// in front of the decoder (adds two cycles of latency to T and Q).
module toggle_decoder
    import toggle_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Qin,
    output logic             T,
    output logic             Q,
    output logic             Qbar,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             ovf,
    output logic             active,
    output logic             stalled
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    logic       qp;
    logic       q_d;
    logic [7:0] idle_cnt;
    state_t     state;
`ifdef TOGGLE_DECODER_SYNC_EN
    sync2 u_sync2 (
        .Clk  (Clk),
        .Reset(Reset),
        .load (Qin),
        .d    (Qin),
        .q    (qp)
    );
`else
    assign qp = Qin;
`endif
    assign Q    = q_d;
    assign Qbar = ~q_d;
    // q_d preloads the live input during reset so release never sees an edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_d        <= Qin;
            T          <= 1'b0;
            toggle_cnt <= '0;
            ovf        <= 1'b0;
        end else begin
            q_d <= qp;
            T   <= qp ^ q_d;
            if (T) begin
                toggle_cnt <= toggle_cnt + 1'b1;
                if (&toggle_cnt) ovf <= 1'b1;
            end
        end
    end
    // A pulse always wins over the timeout, even on the cycle the timeout hits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            idle_cnt <= '0;
            active   <= 1'b0;
            stalled  <= 1'b0;
        end else if (T) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            active   <= 1'b1;
            stalled  <= 1'b0;
        end else if (state == ACTIVE) begin
            idle_cnt <= idle_cnt + 8'd1;
            if (idle_cnt + 8'd1 == TMO) begin
                state   <= STALLED;
                active  <= 1'b0;
                stalled <= 1'b1;
            end
        end else begin
            idle_cnt <= (idle_cnt >= TMO) ? idle_cnt : idle_cnt + 8'd1;
        end
    end
endmodule
